cordic_ctrl_fsm_gen: RTL and testbench
======================================

Name: cordic_ctrl_fsm_gen

Overview:
- Parametrised control FSM for the iterative CORDIC sin/cos datapath.
- Owns its own iteration and variable counters (no external counter ticks) and drives the shared add/subt unit through a beg/ready/ack handshake.
- Applies the quadrant-region final correction and adds a "both" mode that returns cos then sin from one start.
- Adds an add/subt watchdog with an error state.

Parameters:
N_ITER, 16, number of CORDIC micro-rotations (>=2)
ITER_W, 5, width of iter_idx; must hold N_ITER-1
TIMEOUT, 64, max cycles waiting for add_ready; 0 disables watchdog

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin computation (sampled in IDLE)
op_mode  in  2  00 cos, 01 sin, 10 both (cos then sin), 11 treated as cos
region  in  2  shift-region flag of input angle
exception  in  1  input exception flag (sampled in LATCH)
add_ready  in  1  add/subt result valid
out_ack  in  1  consumer accepted result / error
reg_clr  out  1  clear datapath registers
en_in  out  1  load input register bank
en_latch  out  1  latch X/Y/Z operand bank
sel_first  out  1  1 = iteration 0 operands (initial values)
sel_var  out  2  00 X, 01 Y, 10 Z to add/subt
iter_idx  out  ITER_W  current iteration (shift amount / atan ROM address)
add_beg  out  1  start add/subt (1-cycle pulse)
add_ack  out  1  acknowledge add/subt result (1-cycle pulse)
en_x, en_y, en_z  out  1 each  capture result into Xn/Yn/Zn
sel_out  out  1  0 = X path, 1 = Y path to output
en_sign  out  1  enable sign-fix register
en_out  out  1  enable output register
out_valid  out  1  result available
out_is_sin  out  1  tag of presented result
busy  out  1  high in every state except IDLE
error  out  1  watchdog expired

Behaviour:
- Reset: state = CLR, iter_idx = 0, var counter = 0, watchdog = 0, final-phase flag = 0. All outputs are combinational from the state. All outputs except reg_clr and busy are 0 during reset (reg_clr = 1, busy = 1 in CLR).
- CLR (1 cycle): reg_clr = 1; go to IDLE.
- IDLE: waits for start; start latches op_mode into phase_sin (1 only for op 01) and a both flag.
- LOAD (1 cycle): en_in = 1; iter_idx = 0; go to ITER.
- ITER (1 cycle): sel_first = (iter_idx == 0); go to LATCH.
- LATCH (1 cycle): en_latch = 1.
  - exception = 1 -> CLR (abort, no out_valid).
  - otherwise var = 0 -> VAR.
- VAR (1 cycle): sel_var = var; go to GO.
- GO (1 cycle): add_beg = 1, sel_var held; watchdog = 0; go to WAIT.
- WAIT: sel_var held.
  - On add_ready: pulse the enable of the selected variable (var 0 -> en_x, 1 -> en_y, 2 -> en_z), then go to ACK.
  - Otherwise the watchdog increments. If TIMEOUT != 0 and watchdog reaches TIMEOUT-1 without add_ready -> ERR.
- ACK (1 cycle): add_ack = 1.
  - var < 2 -> var++, VAR.
  - Else iter_idx < N_ITER-1 -> iter_idx++, ITER.
  - Else -> FIN (final flag set).
- FIN (1 cycle): tgt = X when (region in {00,11}) XOR phase_sin, else Y. sel_var = tgt; go to GO.
  - In the final pass, WAIT enables only en_x or en_y per tgt.
  - ACK returns to OSEL instead of VAR/ITER.
- OSEL (1 cycle): sel_out = (tgt == Y).
- OSGN (1 cycle): en_sign = 1.
- OREG (1 cycle): en_out = 1.
- DONE: out_valid = 1, out_is_sin = phase_sin. Waits for out_ack.
  - If both = 1 and phase_sin = 0: phase_sin = 1, go to FIN (iterations not repeated).
  - Otherwise -> CLR.
- ERR: error = 1, busy = 1; stays until out_ack -> CLR.
- Simultaneous events:
  - add_ready in the cycle the watchdog would expire: add_ready wins.
  - start outside IDLE is ignored.
  - out_ack outside DONE/ERR is ignored.
- Adder handshake count: exactly 3*N_ITER+1 add_beg pulses per cos/sin result; 3*N_ITER+2 in both mode. Every add_beg is followed by exactly one add_ack unless an error occurs.
- Reset mid-operation: immediate return to CLR, counters zeroed, no out_valid.

Test Plan:
- N_ITER=4, op 00, region 00, add_ready 2 cycles after add_beg, out_ack on 1st DONE cycle -> 13 add_beg, final pulse en_x, sel_out=0, out_valid with out_is_sin=0, then CLR/IDLE.
- op 01, region 01 -> final target X (en_x), sel_out=0, out_is_sin=1. Repeat with region 10 (also en_x).
- op 10, region 00 -> out_valid/out_is_sin=0 then, after out_ack, exactly one extra add_beg, en_y, out_is_sin=1; total 14 add_beg.
- exception=1 in LATCH -> reg_clr next cycle, no add_beg issued, out_valid never asserts.
- TIMEOUT=8, add_ready held low -> error rises after 8 WAIT cycles, holds until out_ack, then reg_clr. add_ready arriving on the expiry cycle -> no error.
- Assert reset during WAIT of iteration 2 -> all outputs drop per reset values (reg_clr=1, busy=1), iter_idx=0; a new start runs a full 13-add sequence.

Source files
------------

// File: rtl/cordic_ctrl_fsm_gen_if.sv
// Control/handshake bundle between the CORDIC control FSM and its datapath / add-subt unit.
interface cordic_ctrl_fsm_gen_if #(
  parameter int unsigned ITER_W = 5
);
  // Requests and status from the datapath side
  logic              start;
  logic [1:0]        op_mode;
  logic [1:0]        region;
  logic              exception;
  logic              add_ready;
  logic              out_ack;

  // Controls driven by the FSM
  logic              reg_clr;
  logic              en_in;
  logic              en_latch;
  logic              sel_first;
  logic [1:0]        sel_var;
  logic [ITER_W-1:0] iter_idx;
  logic              add_beg;
  logic              add_ack;
  logic              en_x;
  logic              en_y;
  logic              en_z;
  logic              sel_out;
  logic              en_sign;
  logic              en_out;
  logic              out_valid;
  logic              out_is_sin;
  logic              busy;
  logic              error;

  modport master (
    input  start, op_mode, region, exception, add_ready, out_ack,
    output reg_clr, en_in, en_latch, sel_first, sel_var, iter_idx, add_beg, add_ack,
           en_x, en_y, en_z, sel_out, en_sign, en_out, out_valid, out_is_sin, busy, error
  );

  modport slave (
    output start, op_mode, region, exception, add_ready, out_ack,
    input  reg_clr, en_in, en_latch, sel_first, sel_var, iter_idx, add_beg, add_ack,
           en_x, en_y, en_z, sel_out, en_sign, en_out, out_valid, out_is_sin, busy, error
  );
endinterface

// File: rtl/cordic_ctrl_fsm_gen.sv
// Control FSM for the iterative CORDIC sin/cos datapath: owns iteration/variable counters,
// sequences the shared add/subt unit, applies the region correction, supports a cos-then-sin
// mode and aborts to an error state if the add/subt unit stops answering.
module cordic_ctrl_fsm_gen #(
  parameter int unsigned N_ITER  = 16,
  parameter int unsigned ITER_W  = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 reset,
  cordic_ctrl_fsm_gen_if.master bus
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);

  typedef enum logic [3:0] {
    StClr, StIdle, StLoad, StIter, StLatch, StVar, StGo, StWait,
    StAck, StFin, StOsel, StOsgn, StOreg, StDone, StErr
  } state_e;

  state_e            state_q;
  logic [ITER_W-1:0] iter_q;
  logic [1:0]        var_q;      // 0 X, 1 Y, 2 Z; holds the correction target in the final pass
  logic [WD_W-1:0]   wd_q;
  logic              final_q;
  logic              phase_sin_q;
  logic              both_q;
  logic              tgt_y;

  // Final correction target: X when (region is 00/11) XOR sin-phase, otherwise Y
  assign tgt_y = ~(((bus.region == 2'b00) || (bus.region == 2'b11)) ^ phase_sin_q);

  // State and counter sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StClr;
      iter_q      <= '0;
      var_q       <= '0;
      wd_q        <= '0;
      final_q     <= 1'b0;
      phase_sin_q <= 1'b0;
      both_q      <= 1'b0;
    end else begin
      case (state_q)
        StClr: begin
          iter_q  <= '0;
          var_q   <= '0;
          wd_q    <= '0;
          final_q <= 1'b0;
          state_q <= StIdle;
        end
        StIdle: begin
          if (bus.start) begin
            phase_sin_q <= (bus.op_mode == 2'b01);
            both_q      <= (bus.op_mode == 2'b10);
            final_q     <= 1'b0;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          iter_q  <= '0;
          state_q <= StIter;
        end
        StIter: state_q <= StLatch;
        StLatch: begin
          if (bus.exception) begin
            state_q <= StClr;
          end else begin
            var_q   <= 2'd0;
            state_q <= StVar;
          end
        end
        StVar: state_q <= StGo;
        StGo: begin
          wd_q    <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A result arriving on the expiry cycle still counts
          if (bus.add_ready) begin
            state_q <= StAck;
          end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
            state_q <= StErr;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StAck: begin
          if (final_q) begin
            state_q <= StOsel;
          end else if (var_q < 2'd2) begin
            var_q   <= var_q + 2'd1;
            state_q <= StVar;
          end else if (iter_q < ITER_LAST) begin
            iter_q  <= iter_q + 1'b1;
            state_q <= StIter;
          end else begin
            final_q <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin: begin
          var_q   <= {1'b0, tgt_y};
          state_q <= StGo;
        end
        StOsel: state_q <= StOsgn;
        StOsgn: state_q <= StOreg;
        StOreg: state_q <= StDone;
        StDone: begin
          if (bus.out_ack) begin
            if (both_q && !phase_sin_q) begin
              // Second result only needs a fresh correction pass
              phase_sin_q <= 1'b1;
              state_q     <= StFin;
            end else begin
              state_q <= StClr;
            end
          end
        end
        StErr: begin
          if (bus.out_ack) state_q <= StClr;
        end
        default: state_q <= StClr;
      endcase
    end
  end

  // Output decode from the current state (result enables also qualified by add_ready)
  always_comb begin
    bus.reg_clr    = 1'b0;
    bus.en_in      = 1'b0;
    bus.en_latch   = 1'b0;
    bus.sel_first  = 1'b0;
    bus.sel_var    = 2'd0;
    bus.iter_idx   = iter_q;
    bus.add_beg    = 1'b0;
    bus.add_ack    = 1'b0;
    bus.en_x       = 1'b0;
    bus.en_y       = 1'b0;
    bus.en_z       = 1'b0;
    bus.sel_out    = 1'b0;
    bus.en_sign    = 1'b0;
    bus.en_out     = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_is_sin = 1'b0;
    bus.busy       = (state_q != StIdle);
    bus.error      = 1'b0;
    case (state_q)
      StClr:   bus.reg_clr   = 1'b1;
      StLoad:  bus.en_in     = 1'b1;
      StIter:  bus.sel_first = (iter_q == '0);
      StLatch: bus.en_latch  = 1'b1;
      StVar:   bus.sel_var   = var_q;
      StGo: begin
        bus.sel_var = var_q;
        bus.add_beg = 1'b1;
      end
      StWait: begin
        bus.sel_var = var_q;
        bus.en_x    = bus.add_ready && (var_q == 2'd0);
        bus.en_y    = bus.add_ready && (var_q == 2'd1);
        bus.en_z    = bus.add_ready && (var_q == 2'd2);
      end
      StAck:   bus.add_ack = 1'b1;
      StFin:   bus.sel_var = {1'b0, tgt_y};
      StOsel:  bus.sel_out = (var_q == 2'd1);
      StOsgn:  bus.en_sign = 1'b1;
      StOreg:  bus.en_out  = 1'b1;
      StDone: begin
        bus.out_valid  = 1'b1;
        bus.out_is_sin = phase_sin_q;
      end
      StErr:   bus.error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_ctrl_fsm_gen.sv
// Self-checking bench for cordic_ctrl_fsm_gen: directed table, timeout/reset corners, random ops.
module tb_cordic_ctrl_fsm_gen;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_ctrl_fsm_gen_if #(.ITER_W(IW)) bus ();

  cordic_ctrl_fsm_gen #(.N_ITER(N), .ITER_W(IW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [1:0] rg;
    bit         exc;
    int         lat;
    int         ack;
    int         exp_begs;
    int         exp_res;
    bit         exp_last_y;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Observed activity of one transaction
  int c_beg, c_ack, c_enx, c_eny, c_enz, c_latch, c_in, c_first, c_clr, c_sign, c_out;
  int c_valid, c_err, seq_err, n_res, err_gap, last_en;
  bit sel_seen;
  bit r_sin[2];
  bit r_y[2];
  bit r_so[2];

  // Reference expectations
  int m_nres, m_begs, m_enx, m_eny, m_enz, m_latch;
  bit m_sin[2];
  bit m_y[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Results implied by the op: list of sin flags, each with its correction target
  task automatic set_model(input logic [1:0] op, input logic [1:0] rg, input bit exc);
    int ny;
    if (exc) m_nres = 0;
    else if (op == 2'b10) m_nres = 2;
    else m_nres = 1;
    m_sin[0] = (op == 2'b01);
    m_sin[1] = 1'b1;
    ny = 0;
    for (int i = 0; i < 2; i++) begin
      m_y[i] = !(((rg == 2'b00) || (rg == 2'b11)) ^ m_sin[i]);
      if (i < m_nres && m_y[i]) ny++;
    end
    m_begs  = exc ? 0 : 3 * N + m_nres;
    m_enx   = exc ? 0 : N + (m_nres - ny);
    m_eny   = exc ? 0 : N + ny;
    m_enz   = exc ? 0 : N;
    m_latch = exc ? 1 : N;
  endtask

  task automatic clear_counts();
    c_beg = 0; c_ack = 0; c_enx = 0; c_eny = 0; c_enz = 0; c_latch = 0; c_in = 0;
    c_first = 0; c_clr = 0; c_sign = 0; c_out = 0; c_valid = 0; c_err = 0; seq_err = 0;
    n_res = 0; err_gap = -1; last_en = 0; sel_seen = 0;
    r_sin = '{0, 0}; r_y = '{0, 0}; r_so = '{0, 0};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg_clr"}, 32'(bus.reg_clr), 1);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    check({tag, "_iter_idx"}, 32'(bus.iter_idx), 0);
    check({tag, "_sel_var"}, 32'(bus.sel_var), 0);
    check({tag, "_others"}, 32'({bus.en_in, bus.en_latch, bus.sel_first, bus.add_beg,
          bus.add_ack, bus.en_x, bus.en_y, bus.en_z, bus.sel_out, bus.en_sign, bus.en_out,
          bus.out_valid, bus.out_is_sin, bus.error}), 0);
  endtask

  // Acts as stimulus source, add/subt unit and consumer for one start..idle transaction
  task automatic run_txn(input logic [1:0] op, input logic [1:0] rg, input bit exc,
                         input int lat, input int ack_dly, input int abort_at);
    int since_beg, valid_run, err_run, k, j;
    bit armed, done;
    clear_counts();
    since_beg = -1; valid_run = 0; err_run = 0; k = 0; armed = 0; done = 0;
    for (int w = 0; w < 8 && bus.busy; w++) @(negedge clk);
    bus.op_mode = op;
    bus.region  = rg;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      if (armed) begin
        bus.add_ready = 1'b0; bus.start = 1'b0; bus.out_ack = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        done  = 1;
      end else if (cyc > 0 && !bus.busy) begin
        done = 1;
      end else begin
        if (since_beg >= 0) since_beg++;
        bus.add_ready = (since_beg == lat);
        bus.start     = (cyc == 0) ? 1'b1 : 1'($urandom_range(1));
        bus.exception = exc;
        valid_run = bus.out_valid ? valid_run + 1 : 0;
        err_run   = bus.error ? err_run + 1 : 0;
        if (bus.out_valid)  bus.out_ack = (valid_run == ack_dly + 1);
        else if (bus.error) bus.out_ack = (err_run == ack_dly + 1);
        else                bus.out_ack = 1'($urandom_range(1));
        if (valid_run == 1) begin
          if (n_res < 2) begin
            r_sin[n_res] = bus.out_is_sin;
            r_y[n_res]   = (last_en == 2);
            r_so[n_res]  = sel_seen;
          end
          n_res++;
          sel_seen = 0;
        end
        if (err_run == 1) err_gap = since_beg;
        #1;
        if (bus.add_beg) begin
          if (k < 3 * N) begin
            if (bus.iter_idx != IW'(k / 3) || bus.sel_var != 2'(k % 3)) seq_err++;
          end else begin
            j = k - 3 * N;
            if (bus.sel_var != ((j < 2 && m_y[j]) ? 2'd1 : 2'd0)) seq_err++;
          end
          if (abort_at >= 0 && int'(bus.iter_idx) == abort_at) armed = 1;
          k++; c_beg++; since_beg = 0;
        end
        if (bus.en_x || bus.en_y || bus.en_z) begin
          if ({bus.en_x, bus.en_y, bus.en_z} != {bus.sel_var == 2'd0, bus.sel_var == 2'd1,
              bus.sel_var == 2'd2}) seq_err++;
          last_en = bus.en_x ? 1 : (bus.en_y ? 2 : 3);
        end
        if (bus.sel_out) sel_seen = 1;
        c_ack   += int'(bus.add_ack);
        c_enx   += int'(bus.en_x);
        c_eny   += int'(bus.en_y);
        c_enz   += int'(bus.en_z);
        c_latch += int'(bus.en_latch);
        c_in    += int'(bus.en_in);
        c_first += int'(bus.sel_first);
        c_clr   += int'(bus.reg_clr);
        c_sign  += int'(bus.en_sign);
        c_out   += int'(bus.en_out);
        c_valid += int'(bus.out_valid);
        c_err   += int'(bus.error);
      end
    end
    bus.start = 1'b0; bus.out_ack = 1'b0; bus.add_ready = 1'b0; bus.exception = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL txn_timeout: got no return to idle, expected idle within 2000 cycles");
    end
  endtask

  task automatic check_model(input int ack_dly);
    check("begs", c_beg, m_begs);
    check("acks", c_ack, m_begs);
    check("results", n_res, m_nres);
    check("en_x", c_enx, m_enx);
    check("en_y", c_eny, m_eny);
    check("en_z", c_enz, m_enz);
    check("en_latch", c_latch, m_latch);
    check("en_in", c_in, 1);
    check("sel_first", c_first, 1);
    check("reg_clr", c_clr, 1);
    check("en_sign", c_sign, m_nres);
    check("en_out", c_out, m_nres);
    check("valid_cycles", c_valid, m_nres * (ack_dly + 1));
    check("error_cycles", c_err, 0);
    check("sequence", seq_err, 0);
    for (int i = 0; i < m_nres && i < 2; i++) begin
      check("is_sin", 32'(r_sin[i]), 32'(m_sin[i]));
      check("final_en_y", 32'(r_y[i]), 32'(m_y[i]));
      check("sel_out", 32'(r_so[i]), 32'(m_y[i]));
    end
  endtask

  vec_t tbl[10];

  initial begin
    int op, rg, lat, ack;
    bit exc;
    tbl[0] = '{2'd0, 2'd0, 1'b0, 2, 0, 13, 1, 1'b0};
    tbl[1] = '{2'd1, 2'd1, 1'b0, 2, 0, 13, 1, 1'b0};
    tbl[2] = '{2'd1, 2'd2, 1'b0, 2, 0, 13, 1, 1'b0};
    tbl[3] = '{2'd2, 2'd0, 1'b0, 2, 0, 14, 2, 1'b1};
    tbl[4] = '{2'd0, 2'd1, 1'b0, 1, 1, 13, 1, 1'b1};
    tbl[5] = '{2'd3, 2'd3, 1'b0, 3, 0, 13, 1, 1'b0};
    tbl[6] = '{2'd1, 2'd0, 1'b0, 2, 0, 13, 1, 1'b1};
    tbl[7] = '{2'd0, 2'd0, 1'b1, 2, 0, 0, 0, 1'b0};
    tbl[8] = '{2'd2, 2'd2, 1'b0, 8, 2, 14, 2, 1'b0};
    tbl[9] = '{2'd0, 2'd0, 1'b0, 8, 0, 13, 1, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.op_mode = 2'd0; bus.region = 2'd0;
    bus.exception = 1'b0; bus.add_ready = 1'b0; bus.out_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    foreach (tbl[i]) begin
      set_model(tbl[i].op, tbl[i].rg, tbl[i].exc);
      run_txn(tbl[i].op, tbl[i].rg, tbl[i].exc, tbl[i].lat, tbl[i].ack, -1);
      check("tbl_begs", c_beg, tbl[i].exp_begs);
      check("tbl_results", n_res, tbl[i].exp_res);
      if (tbl[i].exp_res > 0)
        check("tbl_last_y", (n_res > 0 && n_res <= 2) ? 32'(r_y[n_res-1]) : 2,
              32'(tbl[i].exp_last_y));
      check_model(tbl[i].ack);
    end

    // add/subt never answers: error after TO wait cycles, held until acknowledged
    set_model(2'd0, 2'd0, 1'b0);
    run_txn(2'd0, 2'd0, 1'b0, 99, 2, -1);
    check("to_gap", err_gap, TO + 1);
    check("to_err_cycles", c_err, 3);
    check("to_begs", c_beg, 1);
    check("to_acks", c_ack, 0);
    check("to_valid", c_valid, 0);
    check("to_reg_clr", c_clr, 1);

    // answer one cycle past expiry is too late
    run_txn(2'd1, 2'd0, 1'b0, TO + 1, 0, -1);
    check("late_gap", err_gap, TO + 1);
    check("late_begs", c_beg, 1);

    // reset in WAIT of iteration 2, then a full clean run
    set_model(2'd0, 2'd0, 1'b0);
    run_txn(2'd0, 2'd0, 1'b0, 2, 0, 2);
    check("abort_begs", c_beg, 7);
    check("abort_valid", c_valid, 0);
    run_txn(2'd0, 2'd0, 1'b0, 2, 0, -1);
    check_model(0);

    for (int t = 0; t < 20; t++) begin
      op  = int'($urandom_range(3));
      rg  = int'($urandom_range(3));
      exc = ($urandom_range(7) == 0);
      lat = int'($urandom_range(TO, 1));
      ack = int'($urandom_range(2));
      set_model(2'(op), 2'(rg), exc);
      run_txn(2'(op), 2'(rg), exc, lat, ack, -1);
      check_model(ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
